instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the opcode control decoder: assembles MIPS instruction words from an operation class plus fields.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory.
- Used by the bench and boot path to preload program memory before the CPU is released.
- Opcodes produced are the ones the control decoder recognises: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 10: instruction-memory byte-address width.
- BASE_ADDR, 0: first write address after reset or load_start.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  one clock; reset is synchronous and active-low.
- load_start  input  1  one-cycle pulse: flush FIFO, reload address to BASE_ADDR, clear word_count.
- in_valid  input  1  encode request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- op_sel  input  3  0=R, 1=lw, 2=sw, 3=beq, 4=bne, 5=j, 6/7 illegal.
- rs, rt, rd, shamt  input  5 each  register and shift fields.
- funct  input  6  R-type function field.
- imm  input  16  I-type immediate.
- target  input  26  J-type target.
- imem_ready  input  1  memory accepts write this cycle.
- imem_we  output  1  write request.
- imem_addr  output  ADDR_W  byte address.
- imem_wdata  output  32  instruction word.
- err_illegal  output  1  one-cycle pulse on an accepted illegal op_sel.
- word_count  output  16  words written since reset or load_start; saturates at 0xFFFF.
- busy  output  1  FIFO non-empty.

Behaviour:
- Reset (reset_n=0 at an edge):
  - FIFO empty; imem_addr=BASE_ADDR; word_count=0.
  - err_illegal=0; imem_we=0; busy=0.
  - in_ready=0 during the reset cycle.
  - Reset takes priority over everything else, including mid-stall.
- Encoding is combinational on accepted inputs; the word is pushed at the accepting edge.
  - R: {6'h00, rs, rt, rd, shamt, funct}.
  - lw/sw/beq/bne: {opcode, rs, rt, imm}.
  - j: {6'h02, target}.
  - Fields not used by the class are ignored.
- Illegal op_sel (6/7) is accepted (in_ready honoured) but not pushed; err_illegal=1 on the next cycle only.
- in_ready = !full && !load_start. It is independent of the same-cycle pop, so a full FIFO does not accept even when it is draining.
- Write side:
  - imem_we = busy.
  - imem_wdata = FIFO head; imem_addr = address register.
  - When imem_we && imem_ready: pop the head, add 4 to imem_addr (wraps modulo 2^ADDR_W), increment word_count.
  - When imem_ready=0: addr and wdata are held stable.
- Latency: a word accepted at edge N is first visible on imem_we/imem_wdata after edge N (zero-cycle bubble beyond the register).
- Throughput: 1 word per cycle when imem_ready is held high.
- Push and pop in the same cycle (not full) leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- load_start:
  - Discards FIFO contents and resets addr/count at that edge; no write completes that cycle.
  - Any in_valid in the same cycle is not accepted.
- Two-state control FSM:
  - IDLE (empty) -> ACTIVE on push.
  - ACTIVE -> IDLE when the last entry pops with no simultaneous push, or on load_start/reset.
  - busy reflects ACTIVE.

Test Plan:
- After reset, send lw op_sel=1, rs=16, rt=8, imm=4 with imem_ready=1 -> imem_we=1, imem_addr=0, imem_wdata=0x8E080004 the next cycle; word_count becomes 1.
- Back-to-back R (rs=1, rt=2, rd=3, shamt=0, funct=0x20), sw (rs=29, rt=31, imm=8), beq (rs=1, rt=2, imm=0xFFFF), j (target=0x10) -> words 0x00221820, 0xAFBF0008, 0x1022FFFF, 0x08000010 at addresses 0, 4, 8, 12; word_count=4.
- imem_ready=0, push 5 words with DEPTH=4 -> in_ready drops after the 4th; the 5th is held by the source. Raise imem_ready -> all 5 written in order, addr/wdata stable during the stall.
- op_sel=6 accepted -> err_illegal pulses one cycle, no write, word_count unchanged.
- ADDR_W=4, BASE_ADDR=12, write 2 words -> addresses 12 then 0 (wrap).
- With 3 words buffered and stalled, pulse load_start (then separately reset_n=0) -> FIFO empty, imem_we=0, imem_addr=BASE_ADDR, word_count=0 next cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Assembles MIPS instruction words from an op class and fields,
// buffers them in a FIFO and streams them into instruction memory.
module instr_encoder_loader #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              imem_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err_illegal,
  output logic [15:0]       word_count,
  output logic              busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wc_q, wc_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        legal;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    unique case (op_sel)
      3'd0:    enc_word = {6'h00, rs, rt, rd, shamt, funct};
      3'd1:    enc_word = {6'h23, rs, rt, imm};
      3'd2:    enc_word = {6'h2B, rs, rt, imm};
      3'd3:    enc_word = {6'h04, rs, rt, imm};
      3'd4:    enc_word = {6'h05, rs, rt, imm};
      3'd5:    enc_word = {6'h02, target};
      default: legal    = 1'b0;
    endcase
  end

  // in_ready ignores a same-cycle pop: a full FIFO never accepts
  assign full     = (cnt_q == CW'(DEPTH));
  assign in_ready = reset_n && !full && !load_start;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign busy     = (state_q == ACTIVE);
  assign imem_we  = busy;
  assign pop      = imem_we && imem_ready && !load_start;

  assign imem_addr   = addr_q;
  assign imem_wdata  = mem_q[rd_ptr_q];
  assign err_illegal = err_q;
  assign word_count  = wc_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wc_d     = wc_q;
    err_d    = accept && !legal;
    if (load_start) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      addr_d   = ADDR_W'(BASE_ADDR);
      wc_d     = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + ADDR_W'(4);
        if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      unique case (state_q)
        IDLE:   if (push) state_d = ACTIVE;
        ACTIVE: if (pop && !push && cnt_q == CW'(1)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      wc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wc_q     <= wc_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= enc_word;
  end

endmodule
